// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

  typedef enum logic [1:0] {F_IDLE, F_LEN, F_DATA, F_CSUM} frame_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/imem_uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV + 1);

  rx_state_t        state, state_nxt;
  logic [1:0]       sync_q;
  logic             rx_s, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             half_tick, bit_tick, valid_c, ferr_c;

  assign rx_s      = sync_q[1];
  assign half_tick = (cnt == CNT_W'(DIV / 2 - 1));
  assign bit_tick  = (cnt == CNT_W'(DIV - 1));

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= R_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (rx_prev && !rx_s) state_nxt = R_START;
      R_START: if (half_tick) state_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = R_STOP;
      R_STOP:  if (bit_tick) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    valid_c = 1'b0;
    ferr_c  = 1'b0;
    if (state == R_STOP && bit_tick) begin
      valid_c = rx_s;
      ferr_c  = !rx_s;
    end
  end

  // Baud counter restarts on every state change so each phase is timed from its own start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= valid_c;
      frame_err  <= ferr_c;
      if (valid_c) data <= shreg;
      if (state == R_IDLE || state_nxt != state || bit_tick) cnt <= '0;
      else                                                   cnt <= cnt + CNT_W'(1);
      if (state == R_START)              bit_idx <= '0;
      else if (state == R_DATA && bit_tick) bit_idx <= bit_idx + 3'd1;
      if (state == R_DATA && bit_tick) shreg <= {rx_s, shreg[7:1]};
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program image over UART and writes it word by word into instruction memory,
// holding the CPU in reset until a frame with a correct checksum has been loaded.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr;
  frame_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, waddr_nxt;
  logic [CNT_W-1:0]  nwords, nwords_nxt, words_nxt, len_c;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [23:0]       word_buf, word_buf_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [TO_W-1:0]   tcnt, tcnt_nxt;
  logic [31:0]       wdata_nxt;
  logic              we_nxt, hold_nxt, done_nxt, err_nxt;
  logic              is_sync, len_bad, last_word, timeout_hit, abort;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  assign is_sync     = rx_valid && (rx_data == SYNC_BYTE);
  assign len_c       = (rx_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(rx_data);
  assign len_bad     = (rx_data != 8'd0) && (32'(rx_data) > DEPTH);
  assign last_word   = ((words_loaded + CNT_W'(1)) == nwords);
  assign timeout_hit = (state != F_IDLE) && !rx_valid && (tcnt == TO_W'(TIMEOUT_CYC - 1));
  assign abort       = (state != F_IDLE) && (rx_ferr || timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE: if (is_sync) state_nxt = F_LEN;
      F_LEN:  if (rx_valid) state_nxt = len_bad ? F_IDLE : F_DATA;
      F_DATA: if (rx_valid && byte_idx == 2'd3 && last_word) state_nxt = F_CSUM;
      F_CSUM: if (rx_valid) state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
    if (abort) state_nxt = F_IDLE;
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    addr_nxt     = addr;
    nwords_nxt   = nwords;
    byte_idx_nxt = byte_idx;
    word_buf_nxt = word_buf;
    csum_nxt     = csum;
    words_nxt    = words_loaded;
    waddr_nxt    = imem_addr;
    wdata_nxt    = imem_wdata;
    hold_nxt     = cpu_hold;
    done_nxt     = load_done;
    err_nxt      = load_err;
    we_nxt       = 1'b0;
    tcnt_nxt     = (state == F_IDLE || rx_valid) ? '0 : tcnt + TO_W'(1);
    case (state)
      F_IDLE: if (is_sync) begin
        hold_nxt     = 1'b1;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        addr_nxt     = '0;
        csum_nxt     = '0;
        words_nxt    = '0;
        byte_idx_nxt = '0;
      end
      F_LEN: if (rx_valid) begin
        if (len_bad) err_nxt    = 1'b1;
        else         nwords_nxt = len_c;
      end
      F_DATA: if (rx_valid) begin
        csum_nxt     = csum ^ rx_data;
        byte_idx_nxt = byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_buf_nxt[7:0]   = rx_data;
          2'd1:    word_buf_nxt[15:8]  = rx_data;
          2'd2:    word_buf_nxt[23:16] = rx_data;
          default: begin
            we_nxt    = 1'b1;
            waddr_nxt = addr;
            wdata_nxt = {rx_data, word_buf};
            addr_nxt  = addr + ADDR_W'(1);
            words_nxt = words_loaded + CNT_W'(1);
          end
        endcase
      end
      F_CSUM: if (rx_valid) begin
        if (rx_data == csum) begin
          done_nxt = 1'b1;
          hold_nxt = 1'b0;
        end else begin
          err_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
    if (abort) begin
      err_nxt  = 1'b1;
      done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      nwords       <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      tcnt         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      addr         <= addr_nxt;
      nwords       <= nwords_nxt;
      byte_idx     <= byte_idx_nxt;
      word_buf     <= word_buf_nxt;
      csum         <= csum_nxt;
      tcnt         <= tcnt_nxt;
      imem_we      <= we_nxt;
      imem_addr    <= waddr_nxt;
      imem_wdata   <= wdata_nxt;
      cpu_hold     <= hold_nxt;
      load_done    <= done_nxt;
      load_err     <= err_nxt;
      words_loaded <= words_nxt;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: bit-accurate UART frames from a vector table plus hand-written
// sequences for timeout, framing error, start-bit glitch and reset mid-frame.
module tb_imem_uart_loader;
  localparam int unsigned DIV     = 10;     // 1_152_000 Hz / 115_200 baud
  localparam int unsigned TIMEOUT = 2000;

  logic        clk, rst_n, rx_line;
  logic        imem_we, cpu_hold, load_done, load_err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;

  imem_uart_loader #(
    .CLK_HZ(1_152_000), .BAUD(115_200), .ADDR_W(8), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_line),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  typedef struct {
    logic [0:15][7:0] b;
    int               nb;
    int               nwr;
    logic [31:0]      d0, d1;
    logic             done, err, hold;
    int               wl;
  } vec_t;

  vec_t        vec [3];
  logic [7:0]  wa_q [$];
  logic [31:0] wd_q [$];
  int          n_vec = 0, n_bad = 0, lat_bad = 0, both_bad = 0;
  logic        bv_d = 1'b0, hold_d = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Write capture plus latency / exclusivity watch.
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (rst_n && imem_we && !bv_d) lat_bad++;
    if (rst_n && hold_d && !cpu_hold && !bv_d) lat_bad++;
    if (load_done && load_err) both_bad++;
    bv_d   = dut.rx_valid;
    hold_d = cpu_hold;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx_line = stop;
    repeat (DIV) @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  function automatic logic [63:0] wr_data(input int idx);
    return (wd_q.size() > idx) ? 64'(wd_q[idx]) : {64{1'bx}};
  endfunction

  function automatic logic [63:0] wr_addr(input int idx);
    return (wa_q.size() > idx) ? 64'(wa_q[idx]) : {64{1'bx}};
  endfunction

  task automatic check_flags(input string tag, input logic done, input logic err,
                             input logic hold, input int wl);
    check({tag, " load_done"}, 64'(load_done), 64'(done));
    check({tag, " load_err"}, 64'(load_err), 64'(err));
    check({tag, " cpu_hold"}, 64'(cpu_hold), 64'(hold));
    check({tag, " words_loaded"}, 64'(words_loaded), 64'(wl));
  endtask

  initial begin
    // Good frame: checksum of 13 00 50 00 B3 02 A0 00 is 0x52.
    vec[0].b = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h02, 8'hA0, 8'h00, 8'h52, 40'h0};
    vec[0].nb = 11; vec[0].nwr = 2; vec[0].d0 = 32'h0050_0013; vec[0].d1 = 32'h00A0_02B3;
    vec[0].done = 1'b1; vec[0].err = 1'b0; vec[0].hold = 1'b0; vec[0].wl = 2;
    vec[1].b = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h02, 8'hA0, 8'h00, 8'h00, 40'h0};
    vec[1].nb = 11; vec[1].nwr = 2; vec[1].d0 = 32'h0050_0013; vec[1].d1 = 32'h00A0_02B3;
    vec[1].done = 1'b0; vec[1].err = 1'b1; vec[1].hold = 1'b1; vec[1].wl = 2;
    vec[2].b = {8'h00, 8'h11, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22, 56'h0};
    vec[2].nb = 9; vec[2].nwr = 1; vec[2].d0 = 32'hDEAD_BEEF; vec[2].d1 = 32'h0;
    vec[2].done = 1'b1; vec[2].err = 1'b0; vec[2].hold = 1'b0; vec[2].wl = 1;

    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("reset outputs", {11'd0, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err,
                            words_loaded}, 64'd0);
    rst_n = 1'b1;
    repeat (4 * DIV) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      clear_writes();
      for (int k = 0; k < vec[i].nb; k++) send_byte(vec[i].b[k], 1'b1);
      repeat (3 * DIV) @(negedge clk);
      check($sformatf("v%0d write count", i), 64'(wa_q.size()), 64'(vec[i].nwr));
      if (vec[i].nwr >= 1) begin
        check($sformatf("v%0d addr0", i), wr_addr(0), 64'd0);
        check($sformatf("v%0d data0", i), wr_data(0), 64'(vec[i].d0));
      end
      if (vec[i].nwr >= 2) begin
        check($sformatf("v%0d addr1", i), wr_addr(1), 64'd1);
        check($sformatf("v%0d data1", i), wr_data(1), 64'(vec[i].d1));
      end
      check_flags($sformatf("v%0d", i), vec[i].done, vec[i].err, vec[i].hold, vec[i].wl);
    end

    // Timeout: frame stalls after one data byte.
    clear_writes();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hAA, 1'b1);
    repeat (TIMEOUT - 100) @(negedge clk);
    check("timeout not early", 64'(load_err), 64'd0);
    repeat (110) @(negedge clk);
    check("timeout write count", 64'(wa_q.size()), 64'd0);
    check_flags("timeout", 1'b0, 1'b1, 1'b1, 0);
    foreach (vec[2].b[k]) if (k >= 2 && k < vec[2].nb) send_byte(vec[2].b[k], 1'b1);
    repeat (3 * DIV) @(negedge clk);
    check_flags("after timeout", 1'b1, 1'b0, 1'b0, 1);

    // Stop bit 0 inside the data phase.
    clear_writes();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    check("ferr write count", 64'(wa_q.size()), 64'd0);
    check_flags("ferr", 1'b0, 1'b1, 1'b1, 0);

    // 0.3-bit glitch between sync byte and length must not be taken as a byte.
    clear_writes();
    send_byte(8'hA5, 1'b1);
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    foreach (vec[2].b[k]) if (k >= 3 && k < vec[2].nb) send_byte(vec[2].b[k], 1'b1);
    repeat (3 * DIV) @(negedge clk);
    check("glitch write count", 64'(wa_q.size()), 64'd1);
    check("glitch data0", wr_data(0), 64'h0000_0000_DEAD_BEEF);
    check_flags("glitch", 1'b1, 1'b0, 1'b0, 1);

    // Reset after the 6th data byte of a 4-word frame.
    clear_writes();
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h30 + k), 1'b1);
    check("pre-reset cpu_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-frame reset outputs", {11'd0, imem_we, imem_addr, imem_wdata, cpu_hold, load_done,
                                      load_err, words_loaded}, 64'd0);
    check("mid-frame write count", 64'(wa_q.size()), 64'd1);
    check("mid-frame data0", wr_data(0), 64'h0000_0000_3332_3130);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * DIV) @(negedge clk);
    check("post-reset write count", 64'(wa_q.size()), 64'd1);
    check("post-reset cpu_hold", 64'(cpu_hold), 64'd0);

    check("write/hold latency", 64'(lat_bad), 64'd0);
    check("done/err exclusive", 64'(both_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
